// File: rtl/ysyx_ctrl_fsm.sv
// Multi-cycle control sequencer: fetch, execute, optional data access, single-cycle writeback.
// Owns the bus-timeout watchdog and the mcycle/minstret counters.
module ysyx_ctrl_fsm #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             ifu_req,
  input  logic             ifu_ready,
  input  logic             ifu_rvalid,
  output logic             inst_we,
  input  logic             dec_rf_wr_en,
  input  logic             dec_csr_wr_en,
  input  logic [2:0]       dec_dm_rd_sel,
  input  logic [1:0]       dec_dm_wr_sel,
  input  logic             dec_is_ecall,
  input  logic             dec_is_mret,
  input  logic             dec_is_ebreak,
  output logic             lsu_req,
  output logic             lsu_we,
  input  logic             lsu_ready,
  input  logic             lsu_rvalid,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic             csr_we,
  output logic             trap_we,
  output logic             halted,
  output logic             bus_err,
  output logic [CNT_W-1:0] mcycle,
  output logic [CNT_W-1:0] minstret
);

  // Handshakes: a *_req stays high until *_ready is seen in the same cycle; *_rvalid
  // then completes the access, and may coincide with *_ready to skip the wait state.
  typedef enum logic [2:0] {
    S_IF_REQ   = 3'd0,
    S_IF_WAIT  = 3'd1,
    S_EX       = 3'd2,
    S_MEM_REQ  = 3'd3,
    S_MEM_WAIT = 3'd4,
    S_WB       = 3'd5,
    S_HALT     = 3'd6
  } state_e;

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [TW-1:0]     to_cnt_q, to_cnt_d;
  logic              bus_err_q, bus_err_d;
  logic [CNT_W-1:0]  mcycle_q, mcycle_d;
  logic [CNT_W-1:0]  minstret_q, minstret_d;
  logic              to_last;
  logic              has_mem;

  assign to_last  = (to_cnt_q == TO_LAST);
  assign has_mem  = (dec_dm_rd_sel != 3'd0) || (dec_dm_wr_sel != 2'd0);
  assign halted   = (state_q == S_HALT);
  assign bus_err  = bus_err_q;
  assign mcycle   = mcycle_q;
  assign minstret = minstret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IF_REQ;
      to_cnt_q   <= '0;
      bus_err_q  <= 1'b0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      bus_err_q  <= bus_err_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bus_err_d  = bus_err_q;
    minstret_d = minstret_q;
    mcycle_d   = (state_q == S_HALT) ? mcycle_q : mcycle_q + CNT_W'(1);
    // Saturates at the last count so a late ready still leaves the wait state guarded.
    to_cnt_d   = to_last ? to_cnt_q : to_cnt_q + TW'(1);
    ifu_req    = 1'b0;
    inst_we    = 1'b0;
    lsu_req    = 1'b0;
    lsu_we     = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 2'b00;
    rf_we      = 1'b0;
    csr_we     = 1'b0;
    trap_we    = 1'b0;

    case (state_q)
      S_IF_REQ: begin
        ifu_req = 1'b1;
        if (ifu_ready) begin
          inst_we = ifu_rvalid;
          state_d = ifu_rvalid ? S_EX : S_IF_WAIT;
        end else if (to_last) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end
      end
      S_IF_WAIT: begin
        if (ifu_rvalid) begin
          inst_we = 1'b1;
          state_d = S_EX;
        end else if (to_last) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end
      end
      S_EX: begin
        to_cnt_d = '0;
        if (dec_is_ebreak) begin
          state_d    = S_HALT;
          minstret_d = minstret_q + CNT_W'(1);
        end else if (has_mem) begin
          state_d = S_MEM_REQ;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM_REQ: begin
        lsu_req = 1'b1;
        lsu_we  = (dec_dm_wr_sel != 2'd0);
        if (lsu_ready) begin
          state_d = lsu_rvalid ? S_WB : S_MEM_WAIT;
        end else if (to_last) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (lsu_rvalid) begin
          state_d = S_WB;
        end else if (to_last) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end
      end
      S_WB: begin
        pc_we      = 1'b1;
        rf_we      = dec_rf_wr_en;
        csr_we     = dec_csr_wr_en & ~dec_is_ecall;
        trap_we    = dec_is_ecall;
        pc_sel     = dec_is_ecall ? 2'b01 : (dec_is_mret ? 2'b10 : 2'b00);
        minstret_d = minstret_q + CNT_W'(1);
        to_cnt_d   = '0;
        state_d    = S_IF_REQ;
      end
      S_HALT: begin
        to_cnt_d = to_cnt_q;
      end
      default: begin
        state_d  = S_IF_REQ;
        to_cnt_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_ctrl_fsm.sv
// Directed bench for ysyx_ctrl_fsm: per-cycle expected strobes/counters derived from the
// instruction-level sequencing rules, plus literal spot checks of the counters.
module tb_ysyx_ctrl_fsm;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 64;
  localparam int OW      = 12;
  localparam int EW      = OW + 2 * CNT_W;

  logic clk, rst_n;
  logic ifu_req, ifu_ready, ifu_rvalid, inst_we;
  logic dec_rf_wr_en, dec_csr_wr_en, dec_is_ecall, dec_is_mret, dec_is_ebreak;
  logic [2:0] dec_dm_rd_sel;
  logic [1:0] dec_dm_wr_sel;
  logic lsu_req, lsu_we, lsu_ready, lsu_rvalid;
  logic pc_we, rf_we, csr_we, trap_we, halted, bus_err;
  logic [1:0] pc_sel;
  logic [CNT_W-1:0] mcycle, minstret;

  ysyx_ctrl_fsm #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req(ifu_req), .ifu_ready(ifu_ready), .ifu_rvalid(ifu_rvalid), .inst_we(inst_we),
    .dec_rf_wr_en(dec_rf_wr_en), .dec_csr_wr_en(dec_csr_wr_en),
    .dec_dm_rd_sel(dec_dm_rd_sel), .dec_dm_wr_sel(dec_dm_wr_sel),
    .dec_is_ecall(dec_is_ecall), .dec_is_mret(dec_is_mret), .dec_is_ebreak(dec_is_ebreak),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_ready(lsu_ready), .lsu_rvalid(lsu_rvalid),
    .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .csr_we(csr_we), .trap_we(trap_we),
    .halted(halted), .bus_err(bus_err), .mcycle(mcycle), .minstret(minstret)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] cmp_e, cmp_a;
  logic [CNT_W-1:0] m_cyc, m_ret;
  bit m_berr;

  // strobe vector: ifu_req inst_we lsu_req lsu_we pc_we pc_sel rf_we csr_we trap_we halted bus_err
  function automatic logic [OW-1:0] mk(bit ifq, bit iw, bit lq, bit lw, bit pw, logic [1:0] ps,
                                       bit rw, bit cw, bit tw, bit h, bit be);
    return {ifq, iw, lq, lw, pw, ps, rw, cw, tw, h, be};
  endfunction

  // scoreboard: one expected vector per driven cycle, checked mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cmp_e = exp_q.pop_front();
      cmp_a = {ifu_req, inst_we, lsu_req, lsu_we, pc_we, pc_sel, rf_we, csr_we, trap_we,
               halted, bus_err, mcycle, minstret};
      n_cmp++;
      if (cmp_a !== cmp_e) begin
        n_bad++;
        $display("FAIL cycle_trace t=%0t strobes act=%b exp=%b mcycle act=%0d exp=%0d minstret act=%0d exp=%0d",
                 $time, cmp_a[EW-1 -: OW], cmp_e[EW-1 -: OW],
                 cmp_a[2*CNT_W-1 -: CNT_W], cmp_e[2*CNT_W-1 -: CNT_W],
                 cmp_a[CNT_W-1:0], cmp_e[CNT_W-1:0]);
      end
    end
  end

  task automatic chk(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic cyc(input logic [OW-1:0] o, input bit retire);
    exp_q.push_back({o, m_cyc, m_ret});
    @(posedge clk);
    #1;
    if (!o[1]) m_cyc++;
    if (retire) m_ret++;
  endtask

  task automatic set_hs(input bit is_mem, input bit rdy, input bit rv);
    if (is_mem) begin
      lsu_ready = rdy; lsu_rvalid = rv;
    end else begin
      ifu_ready = rdy; ifu_rvalid = rv;
    end
  endtask

  // Request stage until ready (ready on cycle rdy_dly), then rvalid rv_dly cycles later.
  // The watchdog fires on a cycle at count >= TIMEOUT-1 lacking the awaited handshake.
  task automatic hs_phase(input bit is_mem, input int rdy_dly, input int rv_dly, input bit st,
                          output bit timed_out);
    int cnt = 0;
    bit rdy, rv;
    timed_out = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      rdy = (i == rdy_dly);
      rv  = rdy && (rv_dly == 0);
      set_hs(is_mem, rdy, rv);
      if (!rdy && cnt >= TIMEOUT - 1) timed_out = 1;
      cyc(is_mem ? mk(0, 0, 1, st, 0, 2'b00, 0, 0, 0, 0, 0)
                 : mk(1, rv, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0), 0);
      cnt++;
      if (rdy || timed_out) break;
    end
    if (!timed_out && rv_dly > 0) begin
      for (int j = 1; j <= rv_dly; j++) begin
        rv = (j == rv_dly);
        set_hs(is_mem, 0, rv);
        if (!rv && cnt >= TIMEOUT - 1) timed_out = 1;
        cyc(mk(0, !is_mem && rv, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0), 0);
        cnt++;
        if (timed_out) break;
      end
    end
    if (timed_out) m_berr = 1;
    set_hs(is_mem, 0, 0);
  endtask

  task automatic run_instr(input int f_rdy, input int f_rv, input int m_rdy, input int m_rv,
                           input bit rf, input bit csr, input logic [2:0] rd_sel,
                           input logic [1:0] wr_sel, input bit ecall, input bit mret, input bit ebrk);
    bit to;
    dec_rf_wr_en = rf; dec_csr_wr_en = csr; dec_dm_rd_sel = rd_sel; dec_dm_wr_sel = wr_sel;
    dec_is_ecall = ecall; dec_is_mret = mret; dec_is_ebreak = ebrk;
    hs_phase(0, f_rdy, f_rv, 0, to);
    if (to) return;
    cyc('0, ebrk);
    if (ebrk) return;
    if (rd_sel != 3'd0 || wr_sel != 2'd0) begin
      hs_phase(1, m_rdy, m_rv, wr_sel != 2'd0, to);
      if (to) return;
    end
    cyc(mk(0, 0, 0, 0, 1, ecall ? 2'b01 : (mret ? 2'b10 : 2'b00), rf, csr && !ecall, ecall, 0, 0), 1);
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      ifu_ready  = 1'($urandom_range(0, 1));
      ifu_rvalid = 1'($urandom_range(0, 1));
      lsu_ready  = 1'($urandom_range(0, 1));
      lsu_rvalid = 1'($urandom_range(0, 1));
      cyc(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, m_berr), 0);
    end
    set_hs(0, 0, 0);
    set_hs(1, 0, 0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    set_hs(0, 0, 0);
    set_hs(1, 0, 0);
    m_cyc = '0; m_ret = '0; m_berr = 0;
    exp_q.push_back({mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0), m_cyc, m_ret});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit to;
    rst_n = 1'b0;
    ifu_ready = 0; ifu_rvalid = 0; lsu_ready = 0; lsu_rvalid = 0;
    dec_rf_wr_en = 0; dec_csr_wr_en = 0; dec_dm_rd_sel = '0; dec_dm_wr_sel = '0;
    dec_is_ecall = 0; dec_is_mret = 0; dec_is_ebreak = 0;
    m_cyc = '0; m_ret = '0; m_berr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ifu_req", ifu_req, 1);
    chk("reset_halted", halted, 0);
    chk("reset_mcycle", mcycle, 0);
    rst_n = 1'b1;

    // addi, zero wait: 3 cycles
    run_instr(0, 0, 0, 0, 1, 0, 3'd0, 2'd0, 0, 0, 0);
    chk("addi_mcycle", mcycle, 3);
    chk("addi_minstret", minstret, 1);
    // lw: ready first cycle, rvalid 2 cycles later -> 6 cycles
    run_instr(0, 0, 0, 2, 1, 0, 3'd2, 2'd0, 0, 0, 0);
    chk("lw_mcycle", mcycle, 9);
    // sw with slow fetch and memory: 4 + 1 + 3 + 1 = 9 cycles
    run_instr(2, 1, 1, 1, 0, 0, 3'd0, 2'b11, 0, 0, 0);
    chk("sw_mcycle", mcycle, 18);
    chk("sw_minstret", minstret, 3);
    // ecall with csr write forced, then mret, then zero-wait load
    run_instr(0, 0, 0, 0, 0, 1, 3'd0, 2'd0, 1, 0, 0);
    run_instr(0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 0, 1, 0);
    run_instr(0, 0, 0, 0, 1, 0, 3'd1, 2'd0, 0, 0, 0);
    chk("ld4_mcycle", mcycle, 28);
    chk("ld4_minstret", minstret, 6);
    // handshakes arriving on the last allowed cycle win over the timeout
    run_instr(7, 0, 0, 0, 1, 0, 3'd0, 2'd0, 0, 0, 0);
    run_instr(3, 4, 0, 0, 1, 0, 3'd0, 2'd0, 0, 0, 0);
    chk("late_hs_halted", halted, 0);
    chk("late_hs_minstret", minstret, 8);

    // reset in the middle of a stalled load
    dec_rf_wr_en = 1; dec_csr_wr_en = 0; dec_dm_rd_sel = 3'd2; dec_dm_wr_sel = 2'd0;
    dec_is_ecall = 0; dec_is_mret = 0; dec_is_ebreak = 0;
    hs_phase(0, 0, 0, 0, to);
    cyc('0, 0);
    cyc(mk(0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0), 0);
    cyc(mk(0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0), 0);
    pulse_reset();
    chk("midrst_mcycle", mcycle, 0);
    chk("midrst_minstret", minstret, 0);

    // ebreak halts; handshakes ignored afterwards
    run_instr(0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 1);
    halt_cycles(20);
    chk("ebreak_halted", halted, 1);
    chk("ebreak_bus_err", bus_err, 0);
    chk("ebreak_mcycle", mcycle, 2);
    chk("ebreak_minstret", minstret, 1);
    pulse_reset();

    // fetch never accepted -> 8 request cycles then bus-error halt
    run_instr(100, 0, 0, 0, 1, 0, 3'd0, 2'd0, 0, 0, 0);
    halt_cycles(5);
    chk("if_to_bus_err", bus_err, 1);
    chk("if_to_mcycle", mcycle, 8);
    chk("if_to_minstret", minstret, 0);
    pulse_reset();
    chk("rst_clears_bus_err", bus_err, 0);

    // load never accepted -> bus-error halt from MEM_REQ
    run_instr(0, 0, 100, 0, 1, 0, 3'd4, 2'd0, 0, 0, 0);
    halt_cycles(3);
    chk("mem_to_bus_err", bus_err, 1);
    chk("mem_to_mcycle", mcycle, 10);
    pulse_reset();
    run_instr(0, 0, 0, 0, 1, 0, 3'd0, 2'd0, 0, 0, 0);
    chk("final_minstret", minstret, 1);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_ctrl_fsm.md
Name: ysyx_ctrl_fsm

Overview:
Multi-cycle sequencer for the single-issue core. It drives instruction fetch, holds the fetched instruction while the decoder's control outputs settle, and issues at most one data-memory access per instruction. It then commits the architectural writes (PC, register file, CSR, trap state) in a single writeback cycle. It sits between the fetch/LSU bus handshakes and the decoder, and gates the decoder's write enables so that they fire once per retired instruction.

Parameters:
TIMEOUT, 1024, max cycles spent in any request/wait state before a bus-error halt (≥2)
CNT_W, 64, width of the mcycle/minstret counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ifu_req  out  1  fetch request, held until accepted
ifu_ready  in  1  fetch request accepted
ifu_rvalid  in  1  instruction data valid
inst_we  out  1  load instruction register (1-cycle pulse)
dec_rf_wr_en  in  1  decoder register-file write enable
dec_csr_wr_en  in  1  decoder CSR write enable
dec_dm_rd_sel  in  3  decoder load select, 0 = no load
dec_dm_wr_sel  in  2  decoder store select, 0 = no store
dec_is_ecall  in  1  decoded ecall
dec_is_mret  in  1  decoded mret
dec_is_ebreak  in  1  decoded ebreak
lsu_req  out  1  data-memory request, held until accepted
lsu_we  out  1  1 = store, 0 = load; valid while lsu_req
lsu_ready  in  1  data request accepted
lsu_rvalid  in  1  load data valid / store acknowledged
pc_we  out  1  commit next PC
pc_sel  out  2  00 = normal next-PC, 01 = mtvec, 10 = mepc
rf_we  out  1  gated register-file write
csr_we  out  1  gated CSR write
trap_we  out  1  write mepc = pc, mcause = 11
halted  out  1  core stopped (sticky)
bus_err  out  1  halt was caused by timeout (sticky)
mcycle  out  CNT_W  cycle counter
minstret  out  CNT_W  retired-instruction counter

Behaviour:
- Reset (async, any state):
  - state = IF_REQ; timeout counter, mcycle and minstret = 0.
  - halted = bus_err = 0.
  - All strobes are Moore/comb outputs of state and are 0 except ifu_req = 1 in IF_REQ.
- IF_REQ: ifu_req = 1.
  - ifu_ready & ifu_rvalid in the same cycle → inst_we = 1, go to EX.
  - ifu_ready only → go to IF_WAIT.
- IF_WAIT: on ifu_rvalid → inst_we = 1, go to EX. ifu_rvalid is ignored in every other state.
- EX: one cycle; decoder inputs are sampled here and in later states; they stay stable because the instruction register is held.
  - dec_is_ebreak → go to HALT; minstret += 1.
  - Else if dm_rd_sel ≠ 0 or dm_wr_sel ≠ 0 → go to MEM_REQ.
  - Else → go to WB.
- MEM_REQ: lsu_req = 1, lsu_we = (dec_dm_wr_sel ≠ 0).
  - ready & rvalid together → go to WB.
  - ready only → go to MEM_WAIT.
- MEM_WAIT: on lsu_rvalid → go to WB.
- WB: one cycle, then go to IF_REQ; minstret += 1.
  - pc_we = 1.
  - rf_we = dec_rf_wr_en.
  - csr_we = dec_csr_wr_en & ~dec_is_ecall.
  - ecall: trap_we = 1, pc_sel = 01.
  - mret: pc_sel = 10.
  - Otherwise pc_sel = 00.
- HALT: absorbing until reset. halted = 1, all strobes 0, mcycle frozen.
- Timeout:
  - The counter clears on entry to IF_REQ/MEM_REQ and increments each cycle in IF_REQ, IF_WAIT, MEM_REQ and MEM_WAIT.
  - When count == TIMEOUT−1 and the awaited handshake is absent that cycle → go to HALT with bus_err = 1; no commit and no minstret increment.
  - A handshake arriving in that same cycle wins.
- Counters:
  - mcycle += 1 every cycle not in HALT.
  - Both counters wrap modulo 2^CNT_W.
- Minimum latency with zero-wait memory: 3 cycles for a non-memory instruction, 4 for a load/store.
- A reset asserted mid-access abandons the access; there is no drain.

Test Plan:
1. Zero-wait addi (dec_rf_wr_en = 1): ifu_ready = ifu_rvalid = 1 → cycle 0 ifu_req + inst_we, cycle 1 EX, cycle 2 pc_we = rf_we = 1, pc_sel = 00; afterwards minstret = 1, mcycle = 3.
2. lw with lsu_ready in the first cycle and lsu_rvalid 2 cycles later → lsu_req for 1 cycle with lsu_we = 0, then MEM_WAIT for 2 cycles, WB with rf_we = 1; 6 cycles total.
3. sw (dm_wr_sel = 11) → lsu_we = 1 during lsu_req; WB has rf_we = 0, pc_we = 1.
4. ecall with dec_csr_wr_en forced to 1 → WB: trap_we = 1, pc_sel = 01, csr_we = 0. Then mret → pc_sel = 10, trap_we = 0.
5. ebreak → halted = 1 the cycle after EX; pc_we never pulses; minstret = 1; ifu_req stays 0 for 20 further cycles.
6. With TIMEOUT = 8 and ifu_ready held at 0 → ifu_req high for 8 cycles, then halted = bus_err = 1. Pulsing rst_n low for 1 cycle mid-sequence → immediate IF_REQ with counters = 0.
